// File: rtl/pd_buffer_ctrl.sv
// Pointer/level controller for the packet-identifier byte ring buffer.
// Optional statistics counters are enabled by defining PD_STATS_EN.
module pd_buffer_ctrl #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int LANES          = 16,
  parameter int BUF_BYTES      = 256,
  localparam int PW            = $clog2(BUF_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    gen,
  input  logic          linkup,
  input  logic          valid_pd,
  input  logic          rd_req,
  input  logic [6:0]    rd_bytes,
  output logic          wr_en,
  output logic [63:0]   wr_mask,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic          rd_ack,
  output logic [PW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overflow,
`ifdef PD_STATS_EN
  output logic [31:0]   beat_cnt,
  output logic [15:0]   drop_cnt,
`endif
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_DOWN   = 2'b00,
    S_ACTIVE = 2'b01,
    S_FLUSH  = 2'b10
  } state_t;

  state_t        r_state;
  logic [2:0]    r_gen_q;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_level;
  logic          r_overflow;

  logic [6:0]    w_b;
  logic [63:0]   w_mask;
  logic [PW:0]   w_free;
  logic          w_space_ok;
  logic          w_wr_en;
  logic          w_drop;
  logic          w_rd_ok;
  logic          w_gen_ok;
  logic [PW:0]   w_lvl_next;

  function automatic logic [6:0] beat_bytes(input logic [2:0] g);
    logic [6:0] b;
    case (g)
      3'b000:  b = 7'((GEN1_PIPEWIDTH / 8) * LANES);
      3'b001:  b = 7'((GEN2_PIPEWIDTH / 8) * LANES);
      3'b010:  b = 7'((GEN3_PIPEWIDTH / 8) * LANES);
      3'b011:  b = 7'((GEN4_PIPEWIDTH / 8) * LANES);
      3'b100:  b = 7'((GEN5_PIPEWIDTH / 8) * LANES);
      default: b = 7'd0;
    endcase
    return b;
  endfunction

  // Beat size, mask, space and read-acceptance decode
  always_comb begin
    w_b        = 7'd0;
    w_mask     = 64'd0;
    w_gen_ok   = (gen <= 3'b100);
    if ((r_state == S_ACTIVE) || (r_state == S_FLUSH)) begin
      w_b = beat_bytes(r_gen_q);
    end else begin
      w_b = 7'd0;
    end
    for (int i = 0; i < 64; i++) begin
      w_mask[i] = (7'(i) < w_b);
    end
    // Free space is judged on the pre-pop level; a same-cycle pop never makes room.
    w_free     = (PW+1)'(BUF_BYTES) - r_level;
    w_space_ok = (w_free >= (PW+1)'(w_b));
    if ((r_state == S_ACTIVE) && valid_pd && linkup && (gen == r_gen_q)) begin
      w_wr_en = w_space_ok;
      w_drop  = !w_space_ok;
    end else begin
      w_wr_en = 1'b0;
      w_drop  = 1'b0;
    end
    if (((r_state == S_ACTIVE) || (r_state == S_FLUSH)) && rd_req &&
        (rd_bytes != 7'd0) && (rd_bytes <= 7'd64) && ((PW+1)'(rd_bytes) <= r_level)) begin
      w_rd_ok = 1'b1;
    end else begin
      w_rd_ok = 1'b0;
    end
    w_lvl_next = r_level
               + (w_wr_en ? (PW+1)'(w_b) : (PW+1)'(0))
               - (w_rd_ok ? (PW+1)'(rd_bytes) : (PW+1)'(0));
  end

  // Link FSM, ring pointers, fill level and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_DOWN;
      r_gen_q    <= 3'b000;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PW'(w_b);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(rd_bytes);
      end
      r_level <= w_lvl_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_DOWN: begin
          if (linkup && w_gen_ok) begin
            r_state <= S_ACTIVE;
            r_gen_q <= gen;
          end
        end
        S_ACTIVE: begin
          if (!linkup || (gen != r_gen_q)) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_lvl_next == '0) begin
            if (linkup && w_gen_ok) begin
              r_state <= S_ACTIVE;
              r_gen_q <= gen;
            end else begin
              r_state <= S_DOWN;
            end
          end
        end
        default: r_state <= S_DOWN;
      endcase
    end
  end

`ifdef PD_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [15:0] r_drop_cnt;

  // Saturating accepted/dropped beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= 32'd0;
      r_drop_cnt <= 16'd0;
    end else begin
      if (w_wr_en && (r_beat_cnt != 32'hFFFF_FFFF)) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

  assign wr_en    = w_wr_en;
  assign wr_mask  = w_mask;
  assign wr_ptr   = r_wr_ptr;
  assign rd_ptr   = r_rd_ptr;
  assign rd_ack   = w_rd_ok;
  assign level    = r_level;
  assign empty    = (r_level == '0);
  assign full     = (w_free < (PW+1)'(w_b));
  assign overflow = r_overflow;
  assign state    = r_state;

endmodule

// File: tb/tb_pd_buffer_ctrl.sv
// Directed self-checking bench for pd_buffer_ctrl (256-byte ring, 16 lanes).
module tb_pd_buffer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  gen;
  logic        linkup, valid_pd, rd_req;
  logic [6:0]  rd_bytes;
  logic        wr_en, rd_ack, empty, full, overflow;
  logic [63:0] wr_mask;
  logic [7:0]  wr_ptr, rd_ptr;
  logic [8:0]  level;
  logic [1:0]  state;
`ifdef PD_STATS_EN
  logic [31:0] beat_cnt;
  logic [15:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pd_buffer_ctrl dut (
    .clk(clk), .rst(rst), .gen(gen), .linkup(linkup), .valid_pd(valid_pd),
    .rd_req(rd_req), .rd_bytes(rd_bytes), .wr_en(wr_en), .wr_mask(wr_mask),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .rd_ack(rd_ack), .level(level),
    .empty(empty), .full(full), .overflow(overflow),
`ifdef PD_STATS_EN
    .beat_cnt(beat_cnt), .drop_cnt(drop_cnt),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; gen = 3'b000; linkup = 1'b0; valid_pd = 1'b1; rd_req = 1'b1; rd_bytes = 7'd1;
    cyc(); cyc();
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_mask", wr_mask, 64'd0);
    rst = 1'b0; linkup = 1'b1; gen = 3'b101; rd_req = 1'b0;
    cyc();
    chk("down_bad_gen", 64'(state), 64'd0);
    chk("down_no_ovf", 64'(overflow), 64'd0);

    // gen3 beat: 64 bytes
    gen = 3'b010; valid_pd = 1'b0;
    cyc();
    chk("t1_active", 64'(state), 64'd1);
    valid_pd = 1'b1; #1;
    chk("t1_wr_en", 64'(wr_en), 64'd1);
    chk("t1_mask", wr_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_wr_ptr0", 64'(wr_ptr), 64'd0);
    cyc(); valid_pd = 1'b0;
    chk("t1_wr_ptr", 64'(wr_ptr), 64'd64);
    chk("t1_level", 64'(level), 64'd64);

    // read acceptance boundaries
    rd_req = 1'b1; rd_bytes = 7'd65; #1;
    chk("t3_rd65", 64'(rd_ack), 64'd0);
    rd_bytes = 7'd0; #1;
    chk("t3_rd0", 64'(rd_ack), 64'd0);
    cyc();
    chk("t3_lvl_hold", 64'(level), 64'd64);
    rd_bytes = 7'd64; #1;
    chk("t3_rd64", 64'(rd_ack), 64'd1);
    cyc(); rd_req = 1'b0;
    chk("t3_level", 64'(level), 64'd0);
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_rd_ptr", 64'(rd_ptr), 64'd64);

    // gen change to gen1 through FLUSH
    gen = 3'b000;
    cyc();
    chk("gc_flush", 64'(state), 64'd2);
    cyc();
    chk("gc_active", 64'(state), 64'd1);
    chk("gc_mask", wr_mask, 64'h0000_0000_0000_FFFF);

    // fill with 16 gen1 beats
    valid_pd = 1'b1;
    repeat (16) cyc();
    chk("t2_level", 64'(level), 64'd256);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_wr_en17", 64'(wr_en), 64'd0);
    chk("t2_ovf_pre", 64'(overflow), 64'd0);
    cyc();
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_lvl_hold", 64'(level), 64'd256);
`ifdef PD_STATS_EN
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("t2_beat_cnt", 64'(beat_cnt), 64'd17);
`endif
    // pop on a full ring does not make room for the same-cycle beat
    rd_req = 1'b1; rd_bytes = 7'd64; #1;
    chk("pp_wr_en", 64'(wr_en), 64'd0);
    chk("pp_rd_ack", 64'(rd_ack), 64'd1);
    cyc(); valid_pd = 1'b0;
    chk("pp_level", 64'(level), 64'd192);
    repeat (3) cyc();
    rd_req = 1'b0;
    chk("drain_level", 64'(level), 64'd0);
    chk("drain_rd_ptr", 64'(rd_ptr), 64'd64);

    // advance to wr_ptr=240, rd_ptr=240
    valid_pd = 1'b1;
    repeat (11) cyc();
    valid_pd = 1'b0;
    chk("t4_wr240", 64'(wr_ptr), 64'd240);
    rd_req = 1'b1;
    cyc(); cyc();
    rd_bytes = 7'd48; cyc();
    rd_req = 1'b0;
    chk("t4_rd240", 64'(rd_ptr), 64'd240);
    chk("t4_lvl0", 64'(level), 64'd0);
    valid_pd = 1'b1; cyc();
    chk("t4_wr_wrap", 64'(wr_ptr), 64'd0);
    cyc(); valid_pd = 1'b0;
    chk("t4_wr16", 64'(wr_ptr), 64'd16);
    rd_req = 1'b1; rd_bytes = 7'd16; cyc();
    chk("t4_rd_wrap", 64'(rd_ptr), 64'd0);
    cyc(); rd_req = 1'b0;
    chk("t4_rd16", 64'(rd_ptr), 64'd16);
    chk("t4_lvl", 64'(level), 64'd0);

    // simultaneous write and read at level 32
    valid_pd = 1'b1; cyc(); cyc();
    chk("t5_lvl32", 64'(level), 64'd32);
    rd_req = 1'b1; rd_bytes = 7'd8; #1;
    chk("t5_wr_en", 64'(wr_en), 64'd1);
    chk("t5_rd_ack", 64'(rd_ack), 64'd1);
    cyc(); valid_pd = 1'b0;
    chk("t5_level", 64'(level), 64'd40);
    cyc(); rd_req = 1'b0;
    valid_pd = 1'b1; cyc(); valid_pd = 1'b0;
    chk("t6_lvl48", 64'(level), 64'd48);
    chk("t6_wr_ptr", 64'(wr_ptr), 64'd80);

    // link drop with 48 bytes stored
    linkup = 1'b0; valid_pd = 1'b1; #1;
    chk("t6_wr_en_ld", 64'(wr_en), 64'd0);
    cyc();
    chk("t6_flush", 64'(state), 64'd2);
    chk("t6_wr_en_fl", 64'(wr_en), 64'd0);
    valid_pd = 1'b0; rd_req = 1'b1; rd_bytes = 7'd16;
    cyc(); cyc();
    chk("t6_still_fl", 64'(state), 64'd2);
    chk("t6_lvl16", 64'(level), 64'd16);
    cyc(); rd_req = 1'b0;
    chk("t6_down", 64'(state), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_rd_ptr", 64'(rd_ptr), 64'd80);
    chk("t6_mask_down", wr_mask, 64'd0);

    // gen3 -> gen2 change while up
    linkup = 1'b1; gen = 3'b010; cyc();
    chk("t6_up", 64'(state), 64'd1);
    gen = 3'b001; cyc();
    chk("t6_gc_flush", 64'(state), 64'd2);
    cyc();
    chk("t6_gc_active", 64'(state), 64'd1);
    chk("t6_gen2_mask", wr_mask, 64'h0000_0000_FFFF_FFFF);
    valid_pd = 1'b1; cyc(); valid_pd = 1'b0;
    chk("t6_gen2_wr", 64'(wr_ptr), 64'd112);
    chk("t6_gen2_lvl", 64'(level), 64'd32);

    // reset mid-operation discards content
    rst = 1'b1; cyc(); rst = 1'b0; linkup = 1'b0;
    chk("rst2_level", 64'(level), 64'd0);
    chk("rst2_ovf", 64'(overflow), 64'd0);
    chk("rst2_state", 64'(state), 64'd0);
    chk("rst2_wr_ptr", 64'(wr_ptr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
